// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers.
//   WORD_WIDTH_DEFAULT / NUM_FIELDS_DEFAULT : default entry geometry
//                                             (instr, PC, PC+4).
//   entry_t : one held entry, a valid bit plus the packed field vector,
//             at the default geometry. Stages built with other widths
//             declare a struct of the same shape ({valid, data}) and pass
//             it to pipe_entry_reg as its entry type.
package pipe_pkg;

    localparam int WORD_WIDTH_DEFAULT = 32;
    localparam int NUM_FIELDS_DEFAULT = 3;

    typedef struct packed {
        logic                                             valid;
        logic [NUM_FIELDS_DEFAULT*WORD_WIDTH_DEFAULT-1:0] data;
    } entry_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One entry register: a valid bit plus its field vector.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//                (reset zeroes valid and data).
//   load       : capture d (the caller sets d.valid).
//   clear      : drop the entry (valid=0). It has priority over load.
//   clear_data : together with clear, also zero the data; otherwise the
//                stale data is kept so the output holds its last value.
//   d, q       : next / current entry; entry_t must have the fields
//                valid and data.
module pipe_entry_reg #(
    parameter type entry_t = pipe_pkg::entry_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  logic   clear,
    input  logic   clear_data,
    input  entry_t d,
    output entry_t q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clear) begin
            q.valid <= 1'b0;
            if (clear_data) begin
                q.data <= '0;
            end
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffer pipeline stage with flush.
//   clk, reset           : rising-edge clock, asynchronous active-high reset.
//   flush                : synchronous kill of all held entries and of any
//                          entry offered in the same cycle.
//   in_valid / in_ready  : upstream handshake. in_ready is a register
//                          output (NOT skid.valid), so there is no
//                          combinational path from out_ready.
//   in_data              : NUM_FIELDS fields, field k at [k*WORD_WIDTH +: WORD_WIDTH].
//   out_valid / out_ready: downstream handshake, driven from the main entry.
//   out_data             : main entry fields, same packing as in_data.
//   occupancy            : registered count of valid entries, 0..2.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int WORD_WIDTH     = WORD_WIDTH_DEFAULT,
    parameter int NUM_FIELDS     = NUM_FIELDS_DEFAULT,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_FIELDS*WORD_WIDTH-1:0] in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_FIELDS*WORD_WIDTH-1:0] out_data,
    output logic [1:0]                       occupancy
);

    // Same shape as pipe_pkg::entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic                             valid;
        logic [NUM_FIELDS*WORD_WIDTH-1:0] data;
    } stage_entry_t;

    stage_entry_t main_q, main_d, skid_q, skid_d;
    logic         main_load, main_clear, skid_load, skid_clear;
    logic         clear_data;
    logic         in_xfer, out_xfer;
    logic         main_valid_next, skid_valid_next;
    logic [1:0]   occupancy_q;

    assign in_ready   = ~skid_q.valid;
    assign out_valid  = main_q.valid;
    assign out_data   = main_q.data;
    assign occupancy  = occupancy_q;

    assign in_xfer    = in_valid & in_ready;
    assign out_xfer   = main_q.valid & out_ready;
    assign clear_data = flush & CLEAR_ON_FLUSH;

    always_comb begin
        main_load   = 1'b0;
        main_clear  = 1'b0;
        skid_load   = 1'b0;
        skid_clear  = 1'b0;
        main_d      = '0;
        main_d.valid = 1'b1;
        main_d.data  = in_data;
        skid_d       = main_d;

        if (flush) begin
            // A handshake in the same cycle is still consumed downstream;
            // the offered entry is simply dropped.
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else if (out_xfer) begin
            if (skid_q.valid) begin
                // in_ready is low here, so no input can arrive this cycle.
                main_load  = 1'b1;
                main_d     = skid_q;
                skid_clear = 1'b1;
            end else if (in_xfer) begin
                main_load = 1'b1;
            end else begin
                // Data is kept so out_data holds its last value when empty.
                main_clear = 1'b1;
            end
        end else if (in_xfer) begin
            if (main_q.valid) begin
                skid_load = 1'b1;
            end else begin
                main_load = 1'b1;
            end
        end
    end

    assign main_valid_next = ~main_clear & (main_load | main_q.valid);
    assign skid_valid_next = ~skid_clear & (skid_load | skid_q.valid);

    pipe_entry_reg #(.entry_t(stage_entry_t)) u_main (
        .clk        (clk),
        .reset      (reset),
        .load       (main_load),
        .clear      (main_clear),
        .clear_data (clear_data),
        .d          (main_d),
        .q          (main_q)
    );

    pipe_entry_reg #(.entry_t(stage_entry_t)) u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_load),
        .clear      (skid_clear),
        .clear_data (clear_data),
        .d          (skid_d),
        .q          (skid_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occupancy_q <= 2'd0;
        end else begin
            occupancy_q <= {1'b0, main_valid_next} + {1'b0, skid_valid_next};
        end
    end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter WORD_WIDTH, default 32: width of one field in bits.
REQ-002 Parameter NUM_FIELDS, default 3: fields carried per entry (e.g. instr, PC, PC+4), minimum 1.
REQ-003 Parameter CLEAR_ON_FLUSH, default 1: when 1, invalidated entries have their data zeroed; when 0, data is left stale.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous kill of all held entries.
REQ-007 in_valid  input  1  upstream offers an entry this cycle.
REQ-008 in_ready  output  1  stage can accept an entry this cycle.
REQ-009 in_data  input  NUM_FIELDS*WORD_WIDTH  offered fields; field k occupies bits [k*WORD_WIDTH +: WORD_WIDTH].
REQ-010 out_valid  output  1  stage presents an entry this cycle.
REQ-011 out_ready  input  1  downstream accepts the presented entry.
REQ-012 out_data  output  NUM_FIELDS*WORD_WIDTH  presented fields, same packing as in_data.
REQ-013 occupancy  output  2  number of valid entries held, 0..2.

Function
REQ-014 Storage: two entries, main (drives out_data/out_valid) and skid; each entry is a valid bit plus the field vector.
REQ-015 Input transfer occurs when in_valid and in_ready are both high at a rising edge; output transfer occurs when out_valid and out_ready are both high.
REQ-016 in_ready is a register output equal to NOT skid.valid; it has no combinational path from out_ready.
REQ-017 Latency: an entry accepted into an empty stage appears on out_data one cycle later.
REQ-018 Throughput: with out_ready held high, one entry per cycle passes with no bubbles.
REQ-019 Input accepted with main empty, or with main leaving the same cycle and skid empty: entry loads into main.
REQ-020 Input accepted with main full and not leaving: entry loads into skid.
REQ-021 Output transfer with skid full: skid moves to main and skid becomes empty in the same edge.
REQ-022 Entry order is preserved; no entry is duplicated or dropped except by flush.
REQ-023 When empty, out_valid is 0 and out_data holds its last value, or zero if CLEAR_ON_FLUSH=1 and the last event was a flush.
REQ-024 flush has priority over all transfers: at the edge, main.valid and skid.valid are cleared, any entry offered that cycle is dropped, and in_ready is 1 the next cycle.
REQ-025 An output handshake coinciding with flush still counts as consumed downstream; the stage does not re-present it.
REQ-026 occupancy equals main.valid + skid.valid, registered; skid.valid is never 1 while main.valid is 0.

Reset
REQ-027 Asserting reset immediately clears both valid bits, sets all entry data to zero, and sets in_ready=1, out_valid=0, occupancy=0, out_data=0.
REQ-028 Reset asserted mid-transfer discards all held entries; the first post-reset entry follows REQ-017 timing.

Structure
REQ-029 A shared package pipe_pkg holds the WORD_WIDTH default and an entry typedef (valid plus field vector) used by all pipeline stage registers.
REQ-030 One sub-module pipe_entry_reg (valid plus data register with load, clear, async reset) is instantiated twice, as main and skid.

Verification
REQ-031 Reset, then in_valid=1 with in_data={32'h8,32'h4,32'h00500093} and out_ready=1 -> next cycle out_valid=1, out_data equal to it, occupancy=1.
REQ-032 Stream 8 entries, out_ready=1 throughout -> 8 consecutive out_valid cycles in order, in_ready never 0.
REQ-033 out_ready=0, offer A, B, C on consecutive cycles -> A in main, B in skid, in_ready=0 from the cycle after B, C held upstream; raise out_ready -> A, B, C out in order.
REQ-034 Stage holding 2 entries, flush=1 with in_valid=1 (D) -> next cycle occupancy=0, out_valid=0, in_ready=1, D never appears, out_data=0.
REQ-035 Reset asserted asynchronously between edges with occupancy=2 -> out_valid and occupancy drop to 0 before the next edge.
REQ-036 Random in_valid/out_ready/flush for 10000 cycles against a queue scoreboard -> order and count match, occupancy never exceeds 2.
